// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundle of every handshake/bus signal around the memory arbiter: three
// requester ports (0 = audio, 1 = video, 2 = CPU), the single external
// memory port and the sticky status register.
//
// Modports:
//   slave  - used by the arbiter itself (it serves the requesters and
//            drives the memory port)
//   master - used by the surroundings: requesters, memory model, status reader
//
// Signals (N = 0..2):
//   reqN_addr/cs/we/din   requester -> arbiter, cs is a one-cycle strobe
//   reqN_dout/ack         arbiter -> requester, ack is a one-cycle pulse
//   mem_addr/cs/we/din    arbiter -> memory, cs is a one-cycle strobe
//   mem_dout/ack          memory -> arbiter, ack is a one-cycle pulse
//   status                sticky flags, [2:0] overflow, [5:3] timeout
//   status_clr            clears status (a new set in the same cycle wins)
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] req0_addr, req1_addr, req2_addr;
  logic              req0_cs,   req1_cs,   req2_cs;
  logic              req0_we,   req1_we,   req2_we;
  logic [DATA_W-1:0] req0_din,  req1_din,  req2_din;
  logic [DATA_W-1:0] req0_dout, req1_dout, req2_dout;
  logic              req0_ack,  req1_ack,  req2_ack;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_cs;
  logic              mem_we;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic              mem_ack;

  logic [5:0]        status;
  logic              status_clr;

  modport slave (
    input  req0_addr, req1_addr, req2_addr,
    input  req0_cs,   req1_cs,   req2_cs,
    input  req0_we,   req1_we,   req2_we,
    input  req0_din,  req1_din,  req2_din,
    output req0_dout, req1_dout, req2_dout,
    output req0_ack,  req1_ack,  req2_ack,
    output mem_addr, mem_cs, mem_we, mem_din,
    input  mem_dout, mem_ack,
    output status,
    input  status_clr
  );

  modport master (
    output req0_addr, req1_addr, req2_addr,
    output req0_cs,   req1_cs,   req2_cs,
    output req0_we,   req1_we,   req2_we,
    output req0_din,  req1_din,  req2_din,
    input  req0_dout, req1_dout, req2_dout,
    input  req0_ack,  req1_ack,  req2_ack,
    input  mem_addr, mem_cs, mem_we, mem_din,
    output mem_dout, mem_ack,
    input  status,
    output status_clr
  );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one external memory port between three requesters. Each request
// strobe is latched into a one-deep per-port buffer, the buffered requests
// are serialised onto the memory port one at a time, and the read data and
// ack are routed back to the owner. Audio (port 0) always wins; video and
// CPU (ports 1/2) alternate round-robin. A watchdog completes a transaction
// with FILL_DATA if memory never acks.
//
// Ports:
//   clk  - system clock
//   res  - asynchronous active-low reset
//   bus  - mem_arbiter_if.slave: requester ports, memory port, status
//
// Parameters:
//   ADDR_W, DATA_W - address / data width
//   TIMEOUT        - cycles spent in WAIT before forced completion (>= 2)
//   FILL_DATA      - read data returned on timeout (audio silence)
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                TIMEOUT   = 64,
  parameter logic [DATA_W-1:0] FILL_DATA = DATA_W'(32'h80808080)
) (
  input logic          clk,
  input logic          res,
  mem_arbiter_if.slave bus
);

  localparam int               CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t            state_q, state_d;

  // requester inputs gathered into indexable form
  logic [2:0]        req_cs, req_we;
  logic [ADDR_W-1:0] req_addr [3];
  logic [DATA_W-1:0] req_din  [3];

  // one-deep request buffers
  logic [2:0]        pending_q;
  logic [ADDR_W-1:0] addr_q [3];
  logic [2:0]        we_q;
  logic [DATA_W-1:0] din_q  [3];

  logic [1:0]        owner_q, rr_q, winner;
  logic [2:0]        owner_oh;
  logic [CNT_W-1:0]  cnt_q;

  logic              mem_cs_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_din_q;

  logic [2:0]        ack_q, ack_d;
  logic [DATA_W-1:0] dout_q [3];
  logic [5:0]        status_q;

  logic              grant, done, timed_out, mem_cs_d;
  logic [2:0]        clear_mask, accept, overflow, tmo_set;

  assign req_cs      = {bus.req2_cs, bus.req1_cs, bus.req0_cs};
  assign req_we      = {bus.req2_we, bus.req1_we, bus.req0_we};
  assign req_addr[0] = bus.req0_addr;
  assign req_addr[1] = bus.req1_addr;
  assign req_addr[2] = bus.req2_addr;
  assign req_din[0]  = bus.req0_din;
  assign req_din[1]  = bus.req1_din;
  assign req_din[2]  = bus.req2_din;

  assign owner_oh  = 3'b001 << owner_q;
  assign grant     = (state_q == ST_IDLE) && (|pending_q);
  // a real ack always beats the watchdog when both land in the same cycle
  assign done      = (state_q == ST_WAIT) && (bus.mem_ack || (cnt_q == CNT_LAST));
  assign timed_out = (state_q == ST_WAIT) && !bus.mem_ack && (cnt_q == CNT_LAST);

  // The owner's buffer frees up in its completion cycle, so a strobe arriving
  // in that same cycle is taken instead of being counted as an overflow.
  assign clear_mask = done ? owner_oh : 3'b000;
  assign accept     = req_cs & (~pending_q | clear_mask);
  assign overflow   = req_cs & pending_q & ~clear_mask;

  // Audio first; among video/CPU only a tie consults the round-robin pointer.
  always_comb begin
    winner = 2'd0;
    if (pending_q[0])                      winner = 2'd0;
    else if (pending_q[1] && pending_q[2]) winner = rr_q;
    else if (pending_q[1])                 winner = 2'd1;
    else if (pending_q[2])                 winner = 2'd2;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant) state_d = ST_WAIT;
      ST_WAIT: if (done)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_cs_d = 1'b0;
    ack_d    = 3'b000;
    tmo_set  = 3'b000;
    case (state_q)
      ST_IDLE: mem_cs_d = grant;
      ST_WAIT: begin
        if (done)      ack_d   = owner_oh;
        if (timed_out) tmo_set = owner_oh;
      end
      default: ;
    endcase
  end

  // Request capture: a new strobe (set) wins over the completion (clear).
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      pending_q <= 3'b000;
      we_q      <= 3'b000;
      for (int n = 0; n < 3; n++) begin
        addr_q[n] <= '0;
        din_q[n]  <= '0;
      end
    end else begin
      pending_q <= (pending_q & ~clear_mask) | accept;
      for (int n = 0; n < 3; n++) begin
        if (accept[n]) begin
          addr_q[n] <= req_addr[n];
          we_q[n]   <= req_we[n];
          din_q[n]  <= req_din[n];
        end
      end
    end
  end

  // Memory side: the address/data registers only load on a grant, so they
  // hold steady for the whole WAIT phase.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      mem_cs_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      owner_q    <= 2'd0;
      rr_q       <= 2'd1;
      cnt_q      <= '0;
    end else begin
      mem_cs_q <= mem_cs_d;
      if (grant) begin
        mem_addr_q <= addr_q[winner];
        mem_we_q   <= we_q[winner];
        mem_din_q  <= din_q[winner];
        owner_q    <= winner;
        cnt_q      <= '0;
        if (winner == 2'd1)      rr_q <= 2'd2;
        else if (winner == 2'd2) rr_q <= 2'd1;
      end else if ((state_q == ST_WAIT) && !done) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Requester side: dout keeps its value between acks.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      ack_q    <= 3'b000;
      status_q <= 6'b000000;
      for (int n = 0; n < 3; n++) dout_q[n] <= '0;
    end else begin
      ack_q    <= ack_d;
      status_q <= (bus.status_clr ? 6'b000000 : status_q) | {tmo_set, overflow};
      for (int n = 0; n < 3; n++) begin
        if (ack_d[n]) dout_q[n] <= bus.mem_ack ? bus.mem_dout : FILL_DATA;
      end
    end
  end

  assign bus.mem_cs    = mem_cs_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_din   = mem_din_q;
  assign bus.req0_ack  = ack_q[0];
  assign bus.req1_ack  = ack_q[1];
  assign bus.req2_ack  = ack_q[2];
  assign bus.req0_dout = dout_q[0];
  assign bus.req1_dout = dout_q[1];
  assign bus.req2_dout = dout_q[2];
  assign bus.status    = status_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Scoreboard bench for mem_arbiter. Each stimulus pushes the memory
// transaction(s) it should cause and the acks it should produce; a memory
// model pops and checks every mem_cs and answers after a per-entry latency,
// and an ack monitor pops and checks every reqN_ack. Outputs are sampled on
// the falling edge, inputs are driven on the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int          ADDR_W  = 32;
  localparam int          DATA_W  = 32;
  localparam int          TIMEOUT = 8;
  localparam logic [31:0] FILL    = 32'h80808080;
  localparam logic [31:0] IDLE_DQ = 32'h5A5A5A5A;

  logic clk = 1'b0;
  logic res = 1'b1;
  int   cyc = 0;
  int   n_compared = 0;
  int   n_mismatched = 0;
  int   t0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .TIMEOUT  (TIMEOUT),
    .FILL_DATA(FILL)
  ) dut (
    .clk(clk),
    .res(res),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] rdata;
    int          lat;
    int          at;
  } mem_exp_t;

  typedef struct {
    logic [31:0] dout;
    int          at;
  } ack_exp_t;

  mem_exp_t    mem_q[$];
  ack_exp_t    ack_q0[$], ack_q1[$], ack_q2[$];
  int          ack_cyc = -1;
  logic [31:0] ack_data = '0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input int p, input logic [31:0] addr, input logic we, input logic [31:0] din);
    case (p)
      0: begin bus.req0_addr = addr; bus.req0_we = we; bus.req0_din = din; bus.req0_cs = 1'b1; end
      1: begin bus.req1_addr = addr; bus.req1_we = we; bus.req1_din = din; bus.req1_cs = 1'b1; end
      default: begin bus.req2_addr = addr; bus.req2_we = we; bus.req2_din = din; bus.req2_cs = 1'b1; end
    endcase
  endtask

  task automatic nextCycle();
    @(negedge clk);
    bus.req0_cs    = 1'b0;
    bus.req1_cs    = 1'b0;
    bus.req2_cs    = 1'b0;
    bus.status_clr = 1'b0;
  endtask

  task automatic expectMem(input logic [31:0] addr, input logic we, input logic [31:0] din,
                           input logic [31:0] rdata, input int lat, input int at);
    mem_exp_t e;
    e.addr = addr; e.we = we; e.din = din; e.rdata = rdata; e.lat = lat; e.at = at;
    mem_q.push_back(e);
  endtask

  task automatic expectAck(input int p, input logic [31:0] dout, input int at);
    ack_exp_t e;
    e.dout = dout; e.at = at;
    case (p)
      0: ack_q0.push_back(e);
      1: ack_q1.push_back(e);
      default: ack_q2.push_back(e);
    endcase
  endtask

  task automatic checkAck(input int p, input logic ack, input logic [31:0] dout);
    ack_exp_t e;
    bit       got;
    got    = 1'b0;
    e.dout = '0;
    e.at   = -1;
    if (ack !== 1'b0) begin
      case (p)
        0: if (ack_q0.size() > 0) begin e = ack_q0.pop_front(); got = 1'b1; end
        1: if (ack_q1.size() > 0) begin e = ack_q1.pop_front(); got = 1'b1; end
        default: if (ack_q2.size() > 0) begin e = ack_q2.pop_front(); got = 1'b1; end
      endcase
      if (!got) begin
        checkOutput($sformatf("ack%0d_unexpected", p), 64'(ack), 64'd0);
      end else begin
        checkOutput($sformatf("ack%0d_dout", p), 64'(dout), 64'(e.dout));
        if (e.at >= 0) checkOutput($sformatf("ack%0d_cycle", p), 64'(cyc), 64'(e.at));
      end
    end
  endtask

  function automatic int outstanding();
    return mem_q.size() + ack_q0.size() + ack_q1.size() + ack_q2.size();
  endfunction

  task automatic waitDrain(input string tag, input int budget, input int settle);
    for (int i = 0; i < budget; i++) begin
      if (outstanding() == 0) break;
      nextCycle();
    end
    checkOutput({tag, "_drain"}, 64'(outstanding()), 64'd0);
    mem_q.delete();
    ack_q0.delete();
    ack_q1.delete();
    ack_q2.delete();
    repeat (settle) nextCycle();
  endtask

  // memory model: checks each mem_cs against the scoreboard, acks after lat
  initial begin
    mem_exp_t e;
    bus.mem_ack  = 1'b0;
    bus.mem_dout = IDLE_DQ;
    forever begin
      @(negedge clk);
      if (cyc == ack_cyc) begin
        bus.mem_ack  = 1'b1;
        bus.mem_dout = ack_data;
      end else begin
        bus.mem_ack  = 1'b0;
        bus.mem_dout = IDLE_DQ;
      end
      if (bus.mem_cs === 1'b1) begin
        if (mem_q.size() == 0) begin
          checkOutput("mem_cs_unexpected", 64'(bus.mem_cs), 64'd0);
        end else begin
          e = mem_q.pop_front();
          checkOutput("mem_addr", 64'(bus.mem_addr), 64'(e.addr));
          checkOutput("mem_we", 64'(bus.mem_we), 64'(e.we));
          if (e.we) checkOutput("mem_din", 64'(bus.mem_din), 64'(e.din));
          if (e.at >= 0) checkOutput("mem_cs_cycle", 64'(cyc), 64'(e.at));
          ack_cyc  = cyc + e.lat;
          ack_data = e.rdata;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      checkAck(0, bus.req0_ack, bus.req0_dout);
      checkAck(1, bus.req1_ack, bus.req1_dout);
      checkAck(2, bus.req2_ack, bus.req2_dout);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_watchdog: time %0t, expected completion earlier", $time);
    $fatal(1, "[TB] simulation aborted");
  end

  initial begin
    bus.req0_addr = '0; bus.req1_addr = '0; bus.req2_addr = '0;
    bus.req0_din  = '0; bus.req1_din  = '0; bus.req2_din  = '0;
    bus.req0_we   = 1'b0; bus.req1_we = 1'b0; bus.req2_we = 1'b0;
    bus.req0_cs   = 1'b0; bus.req1_cs = 1'b0; bus.req2_cs = 1'b0;
    bus.status_clr = 1'b0;

    #2 res = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_mem_cs",   64'(bus.mem_cs), 64'd0);
    checkOutput("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    checkOutput("rst_status",   64'(bus.status), 64'd0);
    checkOutput("rst_acks",     64'({bus.req2_ack, bus.req1_ack, bus.req0_ack}), 64'd0);
    checkOutput("rst_dout0",    64'(bus.req0_dout), 64'd0);
    res = 1'b1;
    nextCycle();

    $display("[TB] single audio read");
    t0 = cyc;
    applyStimulus(0, 32'h100, 1'b0, 32'h0);
    expectMem(32'h100, 1'b0, 32'h0, 32'hDEADBEEF, 1, t0 + 2);
    expectAck(0, 32'hDEADBEEF, t0 + 4);
    nextCycle();
    waitDrain("single", 20, 4);
    checkOutput("dout0_hold", 64'(bus.req0_dout), 64'(32'hDEADBEEF));

    $display("[TB] three-way contention");
    t0 = cyc;
    applyStimulus(0, 32'h200, 1'b0, 32'h0);
    applyStimulus(1, 32'h300, 1'b0, 32'h0);
    applyStimulus(2, 32'h400, 1'b1, 32'h12345678);
    expectMem(32'h200, 1'b0, 32'h0,        32'h0A0A0001, 1, t0 + 2);
    expectMem(32'h300, 1'b0, 32'h0,        32'h0B0B0002, 1, t0 + 5);
    expectMem(32'h400, 1'b1, 32'h12345678, 32'h0C0C0003, 1, t0 + 8);
    expectAck(0, 32'h0A0A0001, t0 + 4);
    expectAck(1, 32'h0B0B0002, t0 + 7);
    expectAck(2, 32'h0C0C0003, t0 + 10);
    nextCycle();
    waitDrain("contend3", 40, 3);

    // a lone video grant leaves the round-robin pointer on the CPU
    $display("[TB] lone video read then video/CPU contention");
    t0 = cyc;
    applyStimulus(1, 32'h500, 1'b0, 32'h0);
    expectMem(32'h500, 1'b0, 32'h0, 32'h0D0D0004, 1, t0 + 2);
    expectAck(1, 32'h0D0D0004, t0 + 4);
    nextCycle();
    waitDrain("lone1", 20, 2);

    t0 = cyc;
    applyStimulus(1, 32'h600, 1'b0, 32'h0);
    applyStimulus(2, 32'h700, 1'b1, 32'hCAFEF00D);
    expectMem(32'h700, 1'b1, 32'hCAFEF00D, 32'h0F0F0006, 1, t0 + 2);
    expectMem(32'h600, 1'b0, 32'h0,        32'h0E0E0005, 1, t0 + 5);
    expectAck(2, 32'h0F0F0006, t0 + 4);
    expectAck(1, 32'h0E0E0005, t0 + 7);
    nextCycle();
    waitDrain("contend12", 40, 3);
    checkOutput("status_after_contend", 64'(bus.status), 64'd0);

    $display("[TB] overflow on CPU port");
    t0 = cyc;
    applyStimulus(2, 32'h800, 1'b0, 32'h0);
    expectMem(32'h800, 1'b0, 32'h0, 32'h21212121, 6, t0 + 2);
    expectAck(2, 32'h21212121, t0 + 9);
    nextCycle();
    applyStimulus(2, 32'h900, 1'b1, 32'hFFFF0000);
    nextCycle();
    waitDrain("overflow", 30, 3);
    checkOutput("status_overflow", 64'(bus.status), 64'(6'b000100));
    bus.status_clr = 1'b1;
    nextCycle();
    checkOutput("status_clr", 64'(bus.status), 64'd0);

    $display("[TB] watchdog timeout with late memory ack");
    t0 = cyc;
    applyStimulus(0, 32'hA00, 1'b0, 32'h0);
    expectMem(32'hA00, 1'b0, 32'h0, 32'hBAD0BAD0, TIMEOUT + 1, t0 + 2);
    expectAck(0, FILL, t0 + 2 + TIMEOUT);
    nextCycle();
    waitDrain("timeout", 30, 5);
    checkOutput("status_timeout", 64'(bus.status), 64'(6'b001000));
    checkOutput("dout0_fill_hold", 64'(bus.req0_dout), 64'(FILL));

    $display("[TB] reset during WAIT");
    t0 = cyc;
    applyStimulus(1, 32'hB00, 1'b1, 32'h0F0F0F0F);
    expectMem(32'hB00, 1'b1, 32'h0F0F0F0F, 32'h0, 1000, t0 + 2);
    repeat (4) nextCycle();
    checkOutput("wait_mem_addr", 64'(bus.mem_addr), 64'(32'hB00));
    #2 res = 1'b0;
    #1;
    checkOutput("midrst_mem_cs",   64'(bus.mem_cs), 64'd0);
    checkOutput("midrst_mem_addr", 64'(bus.mem_addr), 64'd0);
    checkOutput("midrst_mem_we",   64'(bus.mem_we), 64'd0);
    checkOutput("midrst_mem_din",  64'(bus.mem_din), 64'd0);
    checkOutput("midrst_status",   64'(bus.status), 64'd0);
    checkOutput("midrst_dout0",    64'(bus.req0_dout), 64'd0);
    checkOutput("midrst_dout1",    64'(bus.req1_dout), 64'd0);
    repeat (2) nextCycle();
    res = 1'b1;
    nextCycle();
    t0 = cyc;
    applyStimulus(1, 32'hC00, 1'b0, 32'h0);
    expectMem(32'hC00, 1'b0, 32'h0, 32'h11112222, 2, t0 + 2);
    expectAck(1, 32'h11112222, t0 + 5);
    nextCycle();
    waitDrain("after_reset", 30, 3);

    $display("[TB] back-to-back audio requests");
    t0 = cyc;
    applyStimulus(0, 32'hD00, 1'b0, 32'h0);
    expectMem(32'hD00, 1'b0, 32'h0, 32'h33334444, 1, t0 + 2);
    expectAck(0, 32'h33334444, t0 + 4);
    repeat (3) nextCycle();
    applyStimulus(0, 32'hD04, 1'b1, 32'h77778888);
    expectMem(32'hD04, 1'b1, 32'h77778888, 32'h55556666, 1, t0 + 5);
    expectAck(0, 32'h55556666, t0 + 7);
    nextCycle();
    waitDrain("b2b", 30, 3);
    checkOutput("status_b2b", 64'(bus.status), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
